// File: rtl/sfx_player_if.sv
// sfx_player_if: groups the trigger, frame-timing and audio status signals of
// the sound-effect player. The master side drives triggers and frame_end; the
// slave side (the player) returns the audio bit and playback status.
interface sfx_player_if;
    logic       frame_end;
    logic       eat_sound;
    logic       hit_sound;
    logic       die_sound;
    logic       sound_out;
    logic       busy;
    logic [1:0] sfx_id;

    modport master (
        output frame_end, eat_sound, hit_sound, die_sound,
        input  sound_out, busy, sfx_id
    );

    modport slave (
        input  frame_end, eat_sound, hit_sound, die_sound,
        output sound_out, busy, sfx_id
    );
endinterface

// File: rtl/sfx_player.sv
// sfx_player: plays one of three fixed 4-note square-wave effects (EAT, HIT,
// DIE). Note pitch is a half-period in clk cycles; note length is counted in
// video frames (frame_end pulses). A half-period of zero is a rest.
// Optional feature macro: SFX_PREEMPT_EN -- when defined, a trigger of strictly
// higher priority than the playing effect restarts playback with the new
// effect; when undefined, triggers are ignored while an effect plays.
module sfx_player #(
    parameter int NOTE_W = 16,
    parameter int DUR_W  = 4
) (
    input  logic         clk,
    input  logic         reset,
    sfx_player_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          note_q, note_d;
    logic [1:0]          id_q, id_d;
    logic [DUR_W-1:0]    frame_q, frame_d;
    logic [NOTE_W-1:0]   cnt_q, cnt_d;
    logic                snd_q, snd_d;

    logic [1:0]          trig_id;
    logic [NOTE_W-1:0]   period;
    logic [DUR_W-1:0]    frame_inc;
    logic                note_over;
    logic                done;
    logic                preempt;
    logic                accept;

    // Half-period table, in clk cycles; zero marks a rest.
    function automatic logic [NOTE_W-1:0] half_period(input logic [1:0] id,
                                                       input logic [1:0] note);
        logic [15:0] p;
        case (id)
            2'd1: begin
                case (note)
                    2'd0:    p = 16'h3000;
                    2'd1:    p = 16'h2800;
                    2'd2:    p = 16'h2000;
                    default: p = 16'h1800;
                endcase
            end
            2'd2:    p = note[0] ? 16'h0000 : 16'h1000;
            2'd3: begin
                case (note)
                    2'd0:    p = 16'h4000;
                    2'd1:    p = 16'h5000;
                    2'd2:    p = 16'h6000;
                    default: p = 16'h8000;
                endcase
            end
            default: p = 16'h0000;
        endcase
        return NOTE_W'(p);
    endfunction

    // Counter value loaded at the start of a note (P-1, or 0 for a rest).
    function automatic logic [NOTE_W-1:0] reload(input logic [1:0] id,
                                                  input logic [1:0] note);
        logic [NOTE_W-1:0] p;
        p = half_period(id, note);
        return (p == '0) ? '0 : p - NOTE_W'(1);
    endfunction

    // Frames per note for each effect.
    function automatic logic [DUR_W-1:0] duration(input logic [1:0] id);
        logic [3:0] d;
        case (id)
            2'd1:    d = 4'd4;
            2'd2:    d = 4'd2;
            2'd3:    d = 4'd8;
            default: d = 4'd0;
        endcase
        return DUR_W'(d);
    endfunction

    // Next-state logic: trigger arbitration, frame counting and tone generation.
    always_comb begin
        trig_id   = bus.die_sound ? 2'd3 :
                    bus.hit_sound ? 2'd2 :
                    bus.eat_sound ? 2'd1 : 2'd0;
        period    = half_period(id_q, note_q);
        frame_inc = frame_q + DUR_W'(1);
        note_over = (state_q == PLAY) && bus.frame_end && (frame_inc == duration(id_q));
        done      = note_over && (note_q == 2'd3);
`ifdef SFX_PREEMPT_EN
        preempt   = (state_q == PLAY) && (trig_id > id_q);
`else
        preempt   = 1'b0;
`endif
        // The completing cycle counts as free, so a trigger there is not lost.
        accept    = (trig_id != 2'd0) && ((state_q == IDLE) || done || preempt);

        state_d = state_q;
        note_d  = note_q;
        id_d    = id_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        snd_d   = snd_q;

        if (accept) begin
            // A coincident frame_end is deliberately not counted here.
            state_d = PLAY;
            id_d    = trig_id;
            note_d  = 2'd0;
            frame_d = '0;
            snd_d   = 1'b0;
            cnt_d   = reload(trig_id, 2'd0);
        end else if (state_q == PLAY) begin
            if (note_over) begin
                frame_d = '0;
                snd_d   = 1'b0;
                if (done) begin
                    state_d = IDLE;
                    id_d    = 2'd0;
                    note_d  = 2'd0;
                    cnt_d   = '0;
                end else begin
                    note_d = note_q + 2'd1;
                    cnt_d  = reload(id_q, note_q + 2'd1);
                end
            end else begin
                if (bus.frame_end) begin
                    frame_d = frame_inc;
                end
                if (period == '0) begin
                    snd_d = 1'b0;
                end else if (cnt_q == '0) begin
                    snd_d = ~snd_q;
                    cnt_d = period - NOTE_W'(1);
                end else begin
                    cnt_d = cnt_q - NOTE_W'(1);
                end
            end
        end
    end

    // Player state register; reset forces silence and IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            note_q  <= 2'd0;
            id_q    <= 2'd0;
            frame_q <= '0;
            cnt_q   <= '0;
            snd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            id_q    <= id_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            snd_q   <= snd_d;
        end
    end

    assign bus.sound_out = snd_q;
    assign bus.busy      = (state_q == PLAY);
    assign bus.sfx_id    = id_q;

endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: scoreboard bench for sfx_player. A note-timing reference
// model predicts busy/sfx_id/sound_out after every clock edge; a monitor pops
// and compares on the falling edge.
module tb_sfx_player;

`ifdef SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sfx_player_if bus ();

    sfx_player #(.NOTE_W(16), .DUR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [1:0] id;
        logic       snd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Effect tables: half-periods per note and frames per note.
    int HP [4][4] = '{'{0, 0, 0, 0},
                      '{'h3000, 'h2800, 'h2000, 'h1800},
                      '{'h1000, 0, 'h1000, 0},
                      '{'h4000, 'h5000, 'h6000, 'h8000}};
    int DUR [4]   = '{0, 4, 2, 8};

    // Model state: effect (0 = none), note, frames elapsed, cycles into note.
    int m_id = 0, m_note = 0, m_frames = 0, m_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   p;
        e.busy = (m_id != 0);
        e.id   = m_id[1:0];
        p      = (m_id != 0) ? HP[m_id][m_note] : 0;
        e.snd  = (p != 0) ? (((m_t / p) % 2) == 1) : 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_id = 0; m_note = 0; m_frames = 0; m_t = 0;
    endtask

    task automatic model_step(input bit e, input bit h, input bit d, input bit fe);
        int trig;
        bit fin, acc;
        if (reset) begin
            model_reset();
            return;
        end
        trig = d ? 3 : (h ? 2 : (e ? 1 : 0));
        fin  = (m_id != 0) && fe && (m_frames + 1 == DUR[m_id]) && (m_note == 3);
        acc  = (trig != 0) && ((m_id == 0) || fin || (PREEMPT && trig > m_id));
        if (acc) begin
            m_id = trig; m_note = 0; m_frames = 0; m_t = 0;
        end else if (m_id != 0) begin
            if (fe) m_frames++;
            if (m_frames == DUR[m_id]) begin
                m_frames = 0;
                m_note++;
                m_t = 0;
                if (m_note == 4) begin
                    m_id = 0;
                    m_note = 0;
                end
            end else begin
                m_t++;
            end
        end
    endtask

    // One clock cycle of stimulus; returns at posedge+1 with inputs cleared.
    task automatic step(input bit e, input bit h, input bit d, input bit fe);
        bus.eat_sound = e;
        bus.hit_sound = h;
        bus.die_sound = d;
        bus.frame_end = fe;
        model_step(e, h, d, fe);
        @(posedge clk);
        q.push_back(model_out());
        #1;
        bus.eat_sound = 1'b0;
        bus.hit_sound = 1'b0;
        bus.die_sound = 1'b0;
        bus.frame_end = 1'b0;
    endtask

    task automatic play_frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) step(0, 0, 0, 0);
            step(0, 0, 0, 1);
        end
    endtask

    // Idle (no frame_end) until sound_out rises; returns cycles waited.
    task automatic first_toggle(input int bound, output int k);
        k = 0;
        while (k < bound) begin
            step(0, 0, 0, 0);
            k++;
            if (bus.sound_out === 1'b1) break;
        end
    endtask

    task automatic run_random(input int n);
        int cd;
        cd = $urandom_range(3, 25);
        for (int i = 0; i < n; i++) begin
            bit       fe;
            bit [2:0] t;
            fe = (cd == 0);
            if (fe) cd = $urandom_range(3, 25);
            else    cd--;
            t = 3'b000;
            if ($urandom_range(0, 149) == 0) t = 3'($urandom_range(1, 7));
            step(t[0], t[1], t[2], fe);
        end
    endtask

    // Scoreboard monitor: compare each predicted output on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_busy",   32'(bus.busy),      32'(e.busy));
                chk("sb_sfx_id", 32'(bus.sfx_id),    32'(e.id));
                chk("sb_sound",  32'(bus.sound_out), 32'(e.snd));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.eat_sound = 1'b0;
        bus.hit_sound = 1'b0;
        bus.die_sound = 1'b0;
        bus.frame_end = 1'b0;

        // Reset held: triggers ignored, outputs idle.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("reset_busy",   32'(bus.busy),      32'd0);
        chk("reset_sfx_id", 32'(bus.sfx_id),    32'd0);
        chk("reset_sound",  32'(bus.sound_out), 32'd0);
        reset = 1'b0;

        // EAT: first toggle after 0x3000 cycles, ends after 16 frames.
        step(1, 0, 0, 0);
        chk("eat_busy",  32'(bus.busy),   32'd1);
        chk("eat_id",    32'(bus.sfx_id), 32'd1);
        first_toggle('h3400, k);
        chk("eat_first_toggle", 32'(k), 32'h3000);
        play_frames(15, 30);
        chk("eat_busy_15", 32'(bus.busy), 32'd1);
        play_frames(1, 30);
        chk("eat_busy_16", 32'(bus.busy), 32'd0);

        // All three triggers together: DIE wins, 32 frames.
        repeat (5) step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("prio_id", 32'(bus.sfx_id), 32'd3);
        first_toggle('h4400, k);
        chk("die_first_toggle", 32'(k), 32'h4000);
        play_frames(31, 20);
        chk("die_busy_31", 32'(bus.busy), 32'd1);
        play_frames(1, 20);
        chk("die_busy_32", 32'(bus.busy), 32'd0);

        // HIT with coincident frame_end: note 0 still lasts 2 long frames.
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        chk("hit_id", 32'(bus.sfx_id), 32'd2);
        play_frames(2, 'h1100);
        play_frames(5, 200);
        chk("hit_busy_7", 32'(bus.busy), 32'd1);
        play_frames(1, 200);
        chk("hit_busy_8", 32'(bus.busy), 32'd0);

        // EAT interrupted by DIE at note 2.
        step(1, 0, 0, 0);
        play_frames(8, 20);
        step(0, 0, 1, 0);
        chk("preempt_id", 32'(bus.sfx_id), PREEMPT ? 32'd3 : 32'd1);
        play_frames(PREEMPT ? 32 : 8, 20);
        chk("preempt_done", 32'(bus.busy), 32'd0);

        // DIE at note 2, asynchronous reset between edges.
        step(0, 0, 1, 0);
        play_frames(16, 20);
        repeat (7) step(0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("async_sound",  32'(bus.sound_out), 32'd0);
        chk("async_busy",   32'(bus.busy),      32'd0);
        chk("async_sfx_id", 32'(bus.sfx_id),    32'd0);
        model_reset();
        q.delete();
        q.push_back(model_out());
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        reset = 1'b0;
        step(1, 0, 0, 0);
        chk("post_reset_id", 32'(bus.sfx_id), 32'd1);
        play_frames(16, 10);
        chk("post_reset_done", 32'(bus.busy), 32'd0);

        // Randomized triggers and frame timing.
        run_random(20000);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
